// File: rtl/multi_button_debouncer.sv
// Multi-channel push-button conditioner: synchroniser, tick-sampled debounce,
// press/release strobes and optional hold-to-repeat per channel.
// The release strobe port is named rel because release is a reserved word.
module multi_button_debouncer #(
    parameter int unsigned          CHANNELS     = 4,
    parameter int unsigned          TICK_DIV     = 100000,
    parameter int unsigned          DEPTH        = 10,
    parameter int unsigned          HOLD_TICKS   = 500,
    parameter int unsigned          REPEAT_TICKS = 100,
    parameter logic [CHANNELS-1:0]  REPEAT_MASK  = {CHANNELS{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] rel,
    output logic [CHANNELS-1:0] held
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAX_T = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEATING
    } hold_state_e;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_comb tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DEPTH-1:0] shreg;
        logic [DEPTH-1:0] shreg_next;
        hold_state_e      state;
        hold_state_e      state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             level_q;
        logic             press_q;
        logic             rel_q;
        logic             held_q;
        logic             rise;
        logic             fall;
        logic             hold_hit;
        logic             rep_hit;
        logic             press_next;
        logic             held_next;

        // Level decisions look at the register contents after this tick's shift.
        always_comb begin
            shreg_next = shreg;
            rise       = 1'b0;
            fall       = 1'b0;
            if (tick) begin
                shreg_next = {shreg[DEPTH-2:0], sync2[c]};
                rise       = (&shreg_next) && !level_q;
                fall       = !(|shreg_next) && level_q;
            end
            hold_hit = tick && (state == PRESSED)   && (cnt == HOLD_LAST);
            rep_hit  = tick && (state == REPEATING) && (cnt == REP_LAST);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end

        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            if (fall) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_next = '0;
                        if (rise) state_next = PRESSED;
                    end
                    PRESSED: begin
                        if (hold_hit) begin
                            state_next = REPEATING;
                            cnt_next   = '0;
                        end else if (tick) begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                    REPEATING: begin
                        if (rep_hit) begin
                            cnt_next = '0;
                        end else if (tick) begin
                            cnt_next = cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end
        end

        // A fall on an expiry tick suppresses the repeat strobe.
        always_comb begin
            press_next = rise || (!fall && (hold_hit || rep_hit) && REPEAT_MASK[c]);
            held_next  = (state_next == REPEATING);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shreg   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                shreg   <= shreg_next;
                press_q <= press_next;
                rel_q   <= fall;
                held_q  <= held_next;
                if (rise) begin
                    level_q <= 1'b1;
                end else if (fall) begin
                    level_q <= 1'b0;
                end
            end
        end

        assign level[c] = level_q;
        assign press[c] = press_q;
        assign rel[c]   = rel_q;
        assign held[c]  = held_q;
    end

endmodule

// File: doc/multi_button_debouncer.md
# multi_button_debouncer

Parametrised, multi-channel push-button conditioner for the alarm-clock front panel. It replaces per-button debounce instances with one block. Each channel has its own input synchroniser, sample shift register, debounced level, and press/release strobes. An optional hold-to-repeat mode generates repeated `press` strobes while a button is held, which the time/alarm setting logic uses for fast increment.

## Interface
Parameters:
- `CHANNELS`, 4, number of independent button channels (≥1)
- `TICK_DIV`, 100000, clocks per sample tick (1 ms at 100 MHz; ≥2)
- `DEPTH`, 10, consecutive equal samples required to change debounced level (≥2)
- `HOLD_TICKS`, 500, ticks of continuous debounced-high before hold is declared (≥1)
- `REPEAT_TICKS`, 100, ticks between auto-repeat strobes once held (≥1)
- `REPEAT_MASK`, {CHANNELS{1'b1}}, per-channel auto-repeat enable

Ports:
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `btn_in`  input  CHANNELS  raw asynchronous button inputs, active-high
- `level`  output  CHANNELS  debounced button level
- `press`  output  CHANNELS  one-clock strobe on debounced rise, and on each auto-repeat
- `release`  output  CHANNELS  one-clock strobe on debounced fall
- `held`  output  CHANNELS  high while a channel is in hold/repeat

## Operation
- Reset (`rst`=0, asynchronous): synchronisers, shift registers, prescaler, hold counters, `level`, `press`, `release` and `held` all clear to 0. Every channel goes to IDLE.
- Prescaler: a shared counter runs 0..TICK_DIV-1 and wraps. The internal `tick` is high for the one clock where count = TICK_DIV-1.
- Synchroniser: each `btn_in` bit passes through 2 flops. The sampled value `s` is the second flop.
- Sampling: on each tick, `s` shifts into that channel's DEPTH-bit register.
  - If the post-shift register is all ones and `level`=0, then `level`←1 and `press`←1 on that same edge.
  - If it is all zeros and `level`=1, then `level`←0 and `release`←1.
  - Any mixed content leaves `level` unchanged. A single differing sample restarts the run.
- `press` and `release` are high for exactly one clock, then return to 0.
- Hold FSM (per channel). The counter has width clog2(max(HOLD_TICKS,REPEAT_TICKS)) and increments only on ticks.
  - IDLE: counter = 0, `held`=0. On debounced rise, go to PRESSED.
  - PRESSED: count ticks. On the tick where counter = HOLD_TICKS-1 and `level` stays 1:
    - `held`←1 and the counter clears.
    - `press`←1 if REPEAT_MASK bit is set.
    - Go to REPEATING.
  - REPEATING: count ticks. On the tick where counter = REPEAT_TICKS-1:
    - `press`←1 if the mask bit is set.
    - The counter clears.
    - Stay in REPEATING.
  - Any state: debounced fall → IDLE with counter←0, `held`←0 on the same edge as `release`.
- Channels are fully independent. Simultaneous events on different channels all produce their strobes on the same edge.

## Timing
- Only one strobe per channel per clock.
- A fall tick coinciding with hold or repeat expiry: release wins. No `press` is issued on that tick; `release`=1 and `held`=0.
- Rise latency from a stable `btn_in` edge: 2 synchroniser clocks, then the DEPTH-th tick sampling high. Minimum latency is 2+(DEPTH-1)·TICK_DIV+1 clocks; maximum is 2+DEPTH·TICK_DIV clocks. Fall latency is identical.
- First repeat `press` comes exactly HOLD_TICKS·TICK_DIV clocks after the initial `press`. Later repeats are spaced REPEAT_TICKS·TICK_DIV clocks apart.
- `held` rises on the same edge as the first repeat point, even when the mask bit is 0.
- Reset mid-operation clears everything immediately. After `rst` deasserts, a button already held down must be re-debounced (full DEPTH ticks) before `press` is issued.
- Outputs are registered. There is no combinational path from `btn_in`.

## Test plan
Bench parameters: CHANNELS=2, TICK_DIV=4, DEPTH=3, HOLD_TICKS=5, REPEAT_TICKS=2, REPEAT_MASK=2'b01.

- Reset: hold `rst`=0 with `btn_in`=2'b11 → all outputs 0. Release `rst` → ch0 `press` no earlier than 2+8+1 clocks and no later than 2+12 clocks.
- Bounce: ch0 toggles every 3 clocks for 40 clocks, then stays high → no `press` during toggling. Exactly one `press` after 3 consecutive high ticks; `level[0]`=1.
- Release: ch0 falls after being stable high → `release[0]` one clock wide within 14 clocks; `level[0]`=0; no spurious `press`.
- Repeat: hold ch0 for 60 clocks after the first `press` → `held[0]` and a `press` at +20 clocks, then `press` at +28, +36, +44, +52.
- Mask: hold ch1 for 60 clocks → `held[1]` rises at +20. Only the initial `press[1]`; no repeats.
- Collision and independence:
  - Time ch0's release so its falling tick equals a repeat tick → `release[0]`=1, `press[0]`=0, `held[0]`=0 on that edge.
  - Ch1 pressed concurrently is unaffected.
  - Assert `rst` while in REPEATING → immediate clear.
